design_select_sequencer: RTL and testbench
==========================================

# design_select_sequencer

Sequences the switch from one user design to another on the shared user area. Accepts a design-select request and holds every design in reset while the outgoing design drains. It then retargets the shared IO mux, waits for the mux to settle, and releases only the newly selected design. It sits directly upstream of the per-design reset synchronizer bank and drives its `designs_cs[12:1]` inputs, where a 1 holds that design in reset.

## Interface
Parameters:
- `DRAIN_CYCLES`, default 4: cycles all designs are held before `io_sel` changes; legal range 1..255.
- `SETTLE_CYCLES`, default 2: cycles after `io_sel` changes before the new design is released; legal range 1..255.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  a select request is present.
- `req_id`  in  4  requested design: 0 = none, 1..12 = design index.
- `req_ready`  out  1  sequencer can accept a request.
- `designs_cs`  out  12  bit i = 1 holds design i in reset; index range [12:1].
- `io_sel`  out  4  IO mux select; 0 = no design owns the pads.
- `active_id`  out  4  currently released design; 0 = none.
- `busy`  out  1  a switch is in progress.
- `done`  out  1  one-cycle pulse when a switch completes.
- `err`  out  1  one-cycle pulse when a request carries an illegal ID (13..15).

## Operation
- Reset values: `designs_cs` = 12'hFFF, `io_sel` = 0, `active_id` = 0, `busy` = 0, `done` = 0, `err` = 0, `req_ready` = 1, state = IDLE.
- States:
  - IDLE: no design is active.
  - ACTIVE: one design is released.
  - DRAIN: all designs held; counting `DRAIN_CYCLES`.
  - SWITCH: one cycle; `io_sel` is loaded.
  - SETTLE: counting `SETTLE_CYCLES`.
- `req_ready` = 1 only in IDLE and ACTIVE. A request is accepted when `req_valid & req_ready`.
- Accepting an illegal ID (13..15):
  - pulses `err` on the next cycle;
  - is then treated exactly as ID 0.
- Accepting an ID equal to `active_id`:
  - pulses `done` on the next cycle;
  - changes no output and no state.
- Accepting any other ID:
  - latches the target ID;
  - next state is DRAIN, with `designs_cs` = 12'hFFF and `busy` = 1.
- DRAIN → SWITCH once the counter expires.
- SWITCH: `io_sel` ← target ID.
  - Target 0 → IDLE.
  - Any other target → SETTLE.
- SETTLE expiry:
  - clears `designs_cs[target]`;
  - sets `active_id` = target;
  - pulses `done`;
  - → ACTIVE.
- Transitions to IDLE from SWITCH set `active_id` = 0 and pulse `done`.
- Invariants, checked by assertions:
  - At most one `designs_cs` bit is 0 at any time.
  - `io_sel` never changes while any `designs_cs` bit is 0.
  - `designs_cs` is 12'hFFF whenever `busy` = 1.
- `req_valid` while `busy` is ignored; the requester holds the request until ready.
- `rst` asserted mid-switch returns every output to its reset value asynchronously. No partially switched state survives.

## Timing
- Acceptance edge = cycle 0. Outputs are registered.
- Cycle 1: `busy` = 1 and `designs_cs` = 12'hFFF.
- DRAIN occupies cycles 1..D, where D = `DRAIN_CYCLES`.
- SWITCH is cycle D+1. The new `io_sel` is visible from cycle D+2.
- Nonzero target:
  - SETTLE occupies cycles D+2..D+1+S, where S = `SETTLE_CYCLES`;
  - at cycle D+2+S, `designs_cs` bit cleared, `active_id` updated, `done` = 1, `busy` = 0, `req_ready` = 1.
- Target 0: `done` = 1 and `active_id` = 0 at cycle D+2.
- The downstream synchronizer adds 2 cycles before the design's `n_rst` rises. This is not counted here.
- Same-ID and illegal-ID responses (`done` or `err`) arrive at cycle 1.

## Structure
- Package `design_sel_pkg` holds:
  - `NUM_DESIGNS` = 12;
  - `DESIGN_ID_W` = 4;
  - `ID_NONE` = 0;
  - the state enum `sel_state_t` (IDLE, ACTIVE, DRAIN, SWITCH, SETTLE);
  - a function mapping an ID to the 12-bit hold mask.
- Sub-module `hold_timer`: loadable 8-bit down-counter with a `load` input, a `value` input, and an `expired` flag. It is shared by DRAIN and SETTLE.

## Test plan
- Reset, then request ID 5 with defaults: `designs_cs` = 12'hFFF through cycle 7; `io_sel` = 5 from cycle 6; `designs_cs` = 12'hFEF and `done` pulse at cycle 8.
- Switch from active design 5 to design 12: `designs_cs` = 12'hFFF from cycle 1; `io_sel` holds 5 through cycle 5 and shows 12 from cycle 6; at cycle 8 `designs_cs` = 12'h7FF and `active_id` = 12.
- Request ID 14 while design 3 is active: `err` at cycle 1, then a full deselect; `io_sel` = 0, `active_id` = 0, `designs_cs` = 12'hFFF, `done` at cycle 6.
- Request the already-active ID 3: `done` at cycle 1; `designs_cs`, `io_sel` and `busy` unchanged.
- Hold `req_valid` with ID 7 during a switch: `req_ready` = 0 while `busy`. The request is accepted the cycle after `done`, and ID 7 is active 8 cycles later.
- Assert `rst` at cycle 3 of DRAIN: all outputs return to reset values in the same cycle. A fresh request for ID 1 after reset completes with `done` at cycle 8.

Source files
------------

// File: rtl/design_sel_pkg.sv
// ---------------------------------------------------------------------------
// design_sel_pkg
// Shared constants, the sequencer state type and the ID-to-hold-mask helper
// for the user-area design select sequencer.
//   NUM_DESIGNS  : number of selectable user designs (indices 1..NUM_DESIGNS)
//   DESIGN_ID_W  : width of a design ID
//   ID_NONE      : ID meaning "no design"
//   sel_state_t  : sequencer FSM state
//   hold_mask()  : 12-bit hold vector with only the given design released
// ---------------------------------------------------------------------------
package design_sel_pkg;

    localparam int NUM_DESIGNS = 12;
    localparam int DESIGN_ID_W = 4;
    localparam logic [DESIGN_ID_W-1:0] ID_NONE = '0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACTIVE = 3'd1,
        DRAIN  = 3'd2,
        SWITCH = 3'd3,
        SETTLE = 3'd4
    } sel_state_t;

    // A 1 holds a design in reset. Every bit is 1 except the bit of the given
    // design; ID_NONE or an out-of-range ID yields all ones.
    function automatic logic [NUM_DESIGNS:1] hold_mask(input logic [DESIGN_ID_W-1:0] id);
        logic [NUM_DESIGNS:1] m;
        for (int i = 1; i <= NUM_DESIGNS; i++) begin
            m[i] = (id != DESIGN_ID_W'(i));
        end
        return m;
    endfunction

endpackage

// File: rtl/design_select_sequencer_hold_timer.sv
// ---------------------------------------------------------------------------
// hold_timer
// Loadable 8-bit down-counter shared by the DRAIN and SETTLE phases.
//   clk     : system clock
//   rst     : asynchronous active-high reset
//   load    : load 'value' into the counter on the next edge
//   value   : number of cycles to count (1..255)
//   expired : high during the last counted cycle
// After a load of N, the counter reads N in the first cycle and 'expired' is
// high in the N-th cycle, so the owner leaves its state after exactly N
// cycles by transitioning on that edge.
// ---------------------------------------------------------------------------
module hold_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] value,
    output logic       expired
);

    logic [7:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 8'd0;
        end else if (load) begin
            r_count <= value;
        end else if (r_count != 8'd0) begin
            r_count <= r_count - 8'd1;
        end
    end

    assign expired = (r_count <= 8'd1);

endmodule

// File: rtl/design_select_sequencer.sv
// ---------------------------------------------------------------------------
// design_select_sequencer
// Switches the shared user area from one design to another: on an accepted
// request it holds every design in reset for DRAIN_CYCLES, retargets the IO
// mux for one cycle, waits SETTLE_CYCLES and then releases only the new
// design. Drives the downstream reset synchronizer bank (1 = hold).
//   clk, rst    : clock, asynchronous active-high reset
//   req_valid   : a select request is present
//   req_id      : requested design, 0 = none, 1..12 = design, 13..15 illegal
//   req_ready   : request accepted when req_valid & req_ready (IDLE/ACTIVE)
//   designs_cs  : [12:1] per-design reset hold
//   io_sel      : IO mux select, 0 = no owner
//   active_id   : currently released design
//   busy        : a switch is in progress
//   done        : one-cycle pulse on switch completion or same-ID request
//   err         : one-cycle pulse when an illegal ID is accepted
// Handshake: req_valid/req_ready follow valid/ready rules; a request moves on
// the edge where both are high, and the requester holds it stable until then.
// ---------------------------------------------------------------------------
module design_select_sequencer
    import design_sel_pkg::*;
#(
    parameter int DRAIN_CYCLES  = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [3:0]  req_id,
    output logic        req_ready,
    output logic [12:1] designs_cs,
    output logic [3:0]  io_sel,
    output logic [3:0]  active_id,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [7:0] DRAIN_V  = 8'(DRAIN_CYCLES);
    localparam logic [7:0] SETTLE_V = 8'(SETTLE_CYCLES);
    localparam logic [3:0] MAX_ID   = 4'(NUM_DESIGNS);

    sel_state_t r_state;
    sel_state_t w_state_nxt;

    logic [NUM_DESIGNS:1] r_cs;
    logic [3:0]           r_io_sel;
    logic [3:0]           r_active_id;
    logic [3:0]           r_target;
    logic                 r_done;
    logic                 r_err;

    logic [NUM_DESIGNS:1] w_cs_nxt;
    logic [3:0]           w_io_sel_nxt;
    logic [3:0]           w_active_nxt;
    logic [3:0]           w_target_nxt;
    logic                 w_done_nxt;
    logic                 w_err_nxt;

    logic                 w_timer_load;
    logic [7:0]           w_timer_value;
    logic                 w_expired;

    logic                 w_ready;
    logic                 w_accept;
    logic                 w_illegal;
    logic [3:0]           w_req_eff;
    logic                 w_same;

    hold_timer u_hold_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (w_timer_load),
        .value   (w_timer_value),
        .expired (w_expired)
    );

    assign w_ready   = (r_state == IDLE) || (r_state == ACTIVE);
    assign w_accept  = req_valid && w_ready;
    assign w_illegal = (req_id > MAX_ID);
    // Illegal IDs behave exactly like a deselect request.
    assign w_req_eff = w_illegal ? ID_NONE : req_id;
    assign w_same    = (w_req_eff == r_active_id);

    // -------------------------------------------------------------- state reg
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------- next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, ACTIVE: begin
                if (w_accept && !w_same) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (w_expired) begin
                    w_state_nxt = SWITCH;
                end
            end
            SWITCH: begin
                w_state_nxt = (r_target == ID_NONE) ? IDLE : SETTLE;
            end
            SETTLE: begin
                if (w_expired) begin
                    w_state_nxt = ACTIVE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ---------------------------------------------------------- output logic
    // Computes next values of the registered outputs plus the timer controls.
    always_comb begin
        w_cs_nxt      = r_cs;
        w_io_sel_nxt  = r_io_sel;
        w_active_nxt  = r_active_id;
        w_target_nxt  = r_target;
        w_done_nxt    = 1'b0;
        w_err_nxt     = 1'b0;
        w_timer_load  = 1'b0;
        w_timer_value = DRAIN_V;
        case (r_state)
            IDLE, ACTIVE: begin
                if (w_accept) begin
                    w_err_nxt = w_illegal;
                    if (w_same) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_target_nxt  = w_req_eff;
                        w_cs_nxt      = '1;
                        w_timer_load  = 1'b1;
                        w_timer_value = DRAIN_V;
                    end
                end
            end
            DRAIN: begin
                w_cs_nxt = '1;
            end
            SWITCH: begin
                w_io_sel_nxt = r_target;
                if (r_target == ID_NONE) begin
                    w_active_nxt = ID_NONE;
                    w_done_nxt   = 1'b1;
                end else begin
                    w_timer_load  = 1'b1;
                    w_timer_value = SETTLE_V;
                end
            end
            SETTLE: begin
                if (w_expired) begin
                    w_cs_nxt     = hold_mask(r_target);
                    w_active_nxt = r_target;
                    w_done_nxt   = 1'b1;
                end
            end
            default: begin
                w_cs_nxt = '1;
            end
        endcase
    end

    // -------------------------------------------------------- output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cs        <= '1;
            r_io_sel    <= ID_NONE;
            r_active_id <= ID_NONE;
            r_target    <= ID_NONE;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_cs        <= w_cs_nxt;
            r_io_sel    <= w_io_sel_nxt;
            r_active_id <= w_active_nxt;
            r_target    <= w_target_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
        end
    end

    assign req_ready  = w_ready;
    assign busy       = !w_ready;
    assign designs_cs = r_cs;
    assign io_sel     = r_io_sel;
    assign active_id  = r_active_id;
    assign done       = r_done;
    assign err        = r_err;

    // ------------------------------------------------------------- invariants
    a_single_release : assert property (@(posedge clk) disable iff (rst)
        $countones(~designs_cs) <= 1);

    a_busy_holds_all : assert property (@(posedge clk) disable iff (rst)
        busy |-> (designs_cs == '1));

    a_io_sel_held : assert property (@(posedge clk) disable iff (rst)
        !$stable(io_sel) |-> ((designs_cs == '1) && ($past(designs_cs) == '1)));

endmodule

// File: tb/tb_design_select_sequencer.sv
// ---------------------------------------------------------------------------
// tb_design_select_sequencer
// Directed bench for design_select_sequencer with default parameters
// (DRAIN_CYCLES = 4, SETTLE_CYCLES = 2). Each scenario task drives a request
// and compares outputs cycle by cycle against hand-computed values. Inputs
// change and outputs are sampled 1 time unit after each rising edge; "cycle k"
// means k edges after the acceptance edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_design_select_sequencer;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [3:0]  req_id;
    logic        req_ready;
    logic [12:1] designs_cs;
    logic [3:0]  io_sel;
    logic [3:0]  active_id;
    logic        busy;
    logic        done;
    logic        err;

    int errors;
    int checks;

    design_select_sequencer #(
        .DRAIN_CYCLES  (4),
        .SETTLE_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_id     (req_id),
        .req_ready  (req_ready),
        .designs_cs (designs_cs),
        .io_sel     (io_sel),
        .active_id  (active_id),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    // ------------------------------------------------------- clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one acceptance edge; returns in cycle 1.
    task automatic send_req(input logic [3:0] id);
        req_id    = id;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    // Checks every output against its reset value.
    task automatic check_reset_values(input string tag);
        checks++;
        if (designs_cs !== 12'hFFF) begin
            $display("FAIL %s designs_cs got=%h exp=fff", tag, designs_cs); errors++;
        end
        checks++;
        if (io_sel !== 4'd0) begin
            $display("FAIL %s io_sel got=%0d exp=0", tag, io_sel); errors++;
        end
        checks++;
        if (active_id !== 4'd0) begin
            $display("FAIL %s active_id got=%0d exp=0", tag, active_id); errors++;
        end
        checks++;
        if ({busy, done, err} !== 3'b000) begin
            $display("FAIL %s busy/done/err got=%b exp=000", tag, {busy, done, err}); errors++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            $display("FAIL %s req_ready got=%b exp=1", tag, req_ready); errors++;
        end
    endtask

    // -------------------------------------------------------------- scenarios
    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 1'b0;
        req_id    = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b0;
        tick();
        check_reset_values("after_reset");
    endtask

    // Full select of design 5 from IDLE.
    task automatic test_first_select();
        logic [12:1] exp_cs;
        logic [3:0]  exp_io;
        logic        exp_done;
        logic        exp_busy;
        send_req(4'd5);
        for (int c = 1; c <= 8; c++) begin
            exp_cs   = (c < 8) ? 12'hFFF : 12'hFEF;
            exp_io   = (c >= 6) ? 4'd5 : 4'd0;
            exp_done = (c == 8);
            exp_busy = (c < 8);
            checks++;
            if (designs_cs !== exp_cs) begin
                $display("FAIL sel5 cs c=%0d got=%h exp=%h", c, designs_cs, exp_cs); errors++;
            end
            checks++;
            if (io_sel !== exp_io) begin
                $display("FAIL sel5 io_sel c=%0d got=%0d exp=%0d", c, io_sel, exp_io); errors++;
            end
            checks++;
            if (done !== exp_done) begin
                $display("FAIL sel5 done c=%0d got=%b exp=%b", c, done, exp_done); errors++;
            end
            checks++;
            if (busy !== exp_busy) begin
                $display("FAIL sel5 busy c=%0d got=%b exp=%b", c, busy, exp_busy); errors++;
            end
            if (c < 8) tick();
        end
        checks++;
        if (active_id !== 4'd5) begin
            $display("FAIL sel5 active_id got=%0d exp=5", active_id); errors++;
        end
    endtask

    // Switch from design 5 to design 12.
    task automatic test_switch();
        logic [12:1] exp_cs;
        logic [3:0]  exp_io;
        send_req(4'd12);
        for (int c = 1; c <= 8; c++) begin
            exp_cs = (c < 8) ? 12'hFFF : 12'h7FF;
            exp_io = (c >= 6) ? 4'd12 : 4'd5;
            checks++;
            if (designs_cs !== exp_cs) begin
                $display("FAIL sw12 cs c=%0d got=%h exp=%h", c, designs_cs, exp_cs); errors++;
            end
            checks++;
            if (io_sel !== exp_io) begin
                $display("FAIL sw12 io_sel c=%0d got=%0d exp=%0d", c, io_sel, exp_io); errors++;
            end
            if (c < 8) tick();
        end
        checks++;
        if (active_id !== 4'd12 || done !== 1'b1) begin
            $display("FAIL sw12 end active_id=%0d done=%b exp 12/1", active_id, done); errors++;
        end
    endtask

    // Move to design 3, then re-request design 3.
    task automatic test_same_id();
        send_req(4'd3);
        repeat (7) tick();
        checks++;
        if (designs_cs !== 12'hFFB || active_id !== 4'd3 || done !== 1'b1) begin
            $display("FAIL sel3 cs=%h active=%0d done=%b exp fffb/3/1", designs_cs, active_id, done);
            errors++;
        end
        tick();
        send_req(4'd3);
        checks++;
        if (done !== 1'b1) begin
            $display("FAIL same3 done got=%b exp=1", done); errors++;
        end
        checks++;
        if (designs_cs !== 12'hFFB || io_sel !== 4'd3 || busy !== 1'b0) begin
            $display("FAIL same3 unchanged cs=%h io=%0d busy=%b exp ffb/3/0", designs_cs, io_sel, busy);
            errors++;
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || active_id !== 4'd3) begin
            $display("FAIL same3 after done=%b busy=%b active=%0d exp 0/0/3", done, busy, active_id);
            errors++;
        end
    endtask

    // Illegal ID 14 while design 3 is active acts as a deselect.
    task automatic test_illegal_id();
        logic [3:0] exp_io;
        logic       exp_done;
        logic       exp_err;
        send_req(4'd14);
        for (int c = 1; c <= 6; c++) begin
            exp_io   = (c >= 6) ? 4'd0 : 4'd3;
            exp_done = (c == 6);
            exp_err  = (c == 1);
            checks++;
            if (err !== exp_err) begin
                $display("FAIL ill14 err c=%0d got=%b exp=%b", c, err, exp_err); errors++;
            end
            checks++;
            if (done !== exp_done) begin
                $display("FAIL ill14 done c=%0d got=%b exp=%b", c, done, exp_done); errors++;
            end
            checks++;
            if (io_sel !== exp_io || designs_cs !== 12'hFFF) begin
                $display("FAIL ill14 io/cs c=%0d got=%0d/%h exp=%0d/fff", c, io_sel, designs_cs, exp_io);
                errors++;
            end
            if (c < 6) tick();
        end
        checks++;
        if (active_id !== 4'd0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            $display("FAIL ill14 end active=%0d busy=%b ready=%b exp 0/0/1", active_id, busy, req_ready);
            errors++;
        end
    endtask

    // Request for 7 held through a switch to 2.
    task automatic test_back_to_back();
        send_req(4'd2);
        req_id    = 4'd7;
        req_valid = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            checks++;
            if (req_ready !== 1'b0 || busy !== 1'b1) begin
                $display("FAIL b2b held c=%0d ready=%b busy=%b exp 0/1", c, req_ready, busy); errors++;
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || active_id !== 4'd2 || designs_cs !== 12'hFFD || req_ready !== 1'b1) begin
            $display("FAIL b2b first done=%b active=%0d cs=%h ready=%b exp 1/2/ffd/1",
                     done, active_id, designs_cs, req_ready);
            errors++;
        end
        tick();
        req_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || designs_cs !== 12'hFFF || done !== 1'b0) begin
            $display("FAIL b2b accept busy=%b cs=%h done=%b exp 1/fff/0", busy, designs_cs, done); errors++;
        end
        repeat (7) tick();
        checks++;
        if (done !== 1'b1 || active_id !== 4'd7 || designs_cs !== 12'hFBF || io_sel !== 4'd7) begin
            $display("FAIL b2b second done=%b active=%0d cs=%h io=%0d exp 1/7/fbf/7",
                     done, active_id, designs_cs, io_sel);
            errors++;
        end
    endtask

    // Reset in the third DRAIN cycle, then a fresh select of design 1.
    task automatic test_reset_mid_switch();
        send_req(4'd1);
        tick();
        tick();
        checks++;
        if (busy !== 1'b1) begin
            $display("FAIL midrst pre busy got=%b exp=1", busy); errors++;
        end
        rst = 1'b1;
        #1;
        check_reset_values("midrst");
        tick();
        rst = 1'b0;
        tick();
        check_reset_values("midrst_post");
        send_req(4'd1);
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if (done !== (c == 8)) begin
                $display("FAIL fresh1 done c=%0d got=%b", c, done); errors++;
            end
            if (c < 8) tick();
        end
        checks++;
        if (designs_cs !== 12'hFFE || active_id !== 4'd1 || io_sel !== 4'd1) begin
            $display("FAIL fresh1 end cs=%h active=%0d io=%0d exp ffe/1/1", designs_cs, active_id, io_sel);
            errors++;
        end
    endtask

    // ------------------------------------------------------------------- main
    initial begin
        errors    = 0;
        checks    = 0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_id    = 4'd0;
        test_reset();
        test_first_select();
        test_switch();
        test_same_id();
        test_illegal_id();
        test_back_to_back();
        test_reset_mid_switch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
